// File: rtl/ram_writer.sv
// Packs received UART bytes MSB-first into RAM words and streams them
// into the frame RAM at linearly increasing, wrapping word addresses.
module ram_writer #(
   parameter  int RAM_WIDTH    = 32,
   parameter  int RAM_DEPTH    = (480*360*24)/RAM_WIDTH,
   localparam int ADDRESS_BITS = $clog2(RAM_DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   input  logic                    frame_start,
   output logic                    we,
   output logic [ADDRESS_BITS-1:0] address,
   output logic [RAM_WIDTH-1:0]    data_out,
   output logic                    frame_done,
   output logic                    busy
);

   localparam int BPW   = RAM_WIDTH/8;
   localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [CNT_W-1:0]        LAST_CNT  = CNT_W'(BPW-1);
   localparam logic [ADDRESS_BITS-1:0] LAST_ADDR = ADDRESS_BITS'(RAM_DEPTH-1);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      WRITE
   } state_t;

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic [RAM_WIDTH-1:0]    r_shift;
   logic [RAM_WIDTH-1:0]    r_data;
   logic [ADDRESS_BITS-1:0] r_addr;
   logic                    r_done;

   logic [RAM_WIDTH-1:0]    w_packed;
   logic [RAM_WIDTH-1:0]    w_first;
   logic                    w_last;
   logic                    w_wrap;

   // Stale upper bytes of r_shift fall off the top before a word completes.
   assign w_packed = (r_shift << 8) | RAM_WIDTH'(rx_data);
   assign w_first  = RAM_WIDTH'(rx_data);
   assign w_last   = (r_cnt == LAST_CNT);
   assign w_wrap   = (r_addr == LAST_ADDR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_addr  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (frame_start) begin
            // A write in flight still uses r_addr this cycle.
            r_addr <= '0;
            if (rx_valid) begin
               r_shift <= w_first;
               if (BPW == 1) begin
                  r_data  <= w_first;
                  r_cnt   <= '0;
                  r_state <= WRITE;
               end else begin
                  r_cnt   <= CNT_W'(1);
                  r_state <= COLLECT;
               end
            end else begin
               r_shift <= '0;
               r_cnt   <= '0;
               r_state <= IDLE;
            end
         end else begin
            if (r_state == WRITE) begin
               r_addr <= w_wrap ? '0 : r_addr + ADDRESS_BITS'(1);
               r_done <= w_wrap;
            end
            if (rx_valid) begin
               r_shift <= w_packed;
               if (w_last) begin
                  r_data  <= w_packed;
                  r_cnt   <= '0;
                  r_state <= WRITE;
               end else begin
                  r_cnt   <= r_cnt + CNT_W'(1);
                  r_state <= COLLECT;
               end
            end else if (r_state == WRITE) begin
               r_state <= IDLE;
            end
         end
      end
   end

   assign we         = (r_state == WRITE);
   assign address    = r_addr;
   assign data_out   = r_data;
   assign frame_done = r_done;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_ram_writer.sv
// Bench for ram_writer: a byte-level reference model pushes expected
// writes and frame_done cycles; a negedge monitor pops and compares.
module tb_ram_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        frame_start;
   logic        we;
   logic [1:0]  address;
   logic [31:0] data_out;
   logic        frame_done;
   logic        busy;

   ram_writer #(
      .RAM_WIDTH (32),
      .RAM_DEPTH (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .frame_start (frame_start),
      .we          (we),
      .address     (address),
      .data_out    (data_out),
      .frame_done  (frame_done),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [1:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t  wq[$];
   int   fdq[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   n_writes = 0;
   int   n_fd = 0;

   int          m_cnt;
   logic [31:0] m_word;
   logic [1:0]  m_addr;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every write and every frame_done pulse against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (we) begin
            n_tests++;
            n_writes++;
            if (wq.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_we cyc=%0d addr=%0d data=%h", cyc, address, data_out);
            end else begin
               wr_t e;
               e = wq.pop_front();
               if (cyc !== e.cyc || address !== e.addr || data_out !== e.data) begin
                  n_fail++;
                  $display("FAIL write got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                           cyc, address, data_out, e.cyc, e.addr, e.data);
               end
            end
         end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL missing_we cyc=%0d want addr=%0d data=%h", cyc, wq[0].addr, wq[0].data);
            void'(wq.pop_front());
         end
         if (frame_done || (fdq.size() > 0 && fdq[0] == cyc)) begin
            logic exp_fd;
            exp_fd = (fdq.size() > 0 && fdq[0] == cyc);
            n_tests++;
            if (frame_done !== exp_fd) begin
               n_fail++;
               $display("FAIL frame_done cyc=%0d got %b want %b", cyc, frame_done, exp_fd);
            end
            if (exp_fd) void'(fdq.pop_front());
         end
         if (frame_done) n_fd++;
      end
   end

   // Drive one cycle of input and advance the model; returns at posedge+1.
   task automatic step(input logic v, input logic [7:0] d, input logic fs);
      rx_valid    = v;
      rx_data     = d;
      frame_start = fs;
      if (fs) begin
         m_cnt  = 0;
         m_word = '0;
         m_addr = '0;
         if (fdq.size() > 0 && fdq[$] == cyc + 1) void'(fdq.pop_back());
      end
      if (v) begin
         m_word = {m_word[23:0], d};
         if (m_cnt == 3) begin
            wr_t e;
            e.cyc  = cyc + 1;
            e.addr = m_addr;
            e.data = m_word;
            wq.push_back(e);
            if (m_addr == 2'd3) fdq.push_back(cyc + 2);
            m_addr = m_addr + 2'd1;
            m_cnt  = 0;
         end else begin
            m_cnt++;
         end
      end
      @(posedge clk);
      #1;
      rx_valid    = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_reset;
      rst         = 1'b1;
      rx_valid    = 1'b0;
      rx_data     = 8'h00;
      frame_start = 1'b0;
      m_cnt       = 0;
      m_word      = '0;
      m_addr      = '0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({we, address, data_out, frame_done, busy} !== 37'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got we=%b addr=%0d data=%h fd=%b busy=%b want all 0",
                  we, address, data_out, frame_done, busy);
      end
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_single_word;
      int w0;
      logic [7:0] bytes [8];
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      w0 = n_writes;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, bytes[i], 1'b0);
         if (i == 0) begin
            n_tests++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL busy_partial got %b want 1", busy);
            end
         end
         idle(2);
      end
      idle(3);
      n_tests++;
      if (n_writes - w0 !== 2) begin
         n_fail++;
         $display("FAIL single_word_count got %0d want 2", n_writes - w0);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_idle got %b want 0", busy);
      end
   endtask

   task automatic test_back_to_back;
      int w0;
      step(1'b0, 8'h00, 1'b1);
      w0 = n_writes;
      for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
      idle(3);
      n_tests++;
      if (n_writes - w0 !== 2) begin
         n_fail++;
         $display("FAIL back_to_back_count got %0d want 2", n_writes - w0);
      end
   endtask

   task automatic test_wrap;
      int w0, f0;
      step(1'b0, 8'h00, 1'b1);
      w0 = n_writes;
      f0 = n_fd;
      for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      idle(4);
      n_tests++;
      if (n_writes - w0 !== 5 || n_fd - f0 !== 1) begin
         n_fail++;
         $display("FAIL wrap_counts got writes=%0d fd=%0d want writes=5 fd=1",
                  n_writes - w0, n_fd - f0);
      end
   endtask

   task automatic test_frame_start_mid;
      int w0;
      w0 = n_writes;
      step(1'b1, 8'hAA, 1'b0);
      step(1'b1, 8'hBB, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
      idle(3);
      n_tests++;
      if (n_writes - w0 !== 1) begin
         n_fail++;
         $display("FAIL fs_mid_count got %0d want 1", n_writes - w0);
      end
   endtask

   task automatic test_fs_during_write;
      int f0;
      f0 = n_fd;
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
      idle(2);
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
      idle(4);
      n_tests++;
      if (n_fd - f0 !== 0) begin
         n_fail++;
         $display("FAIL fs_write_no_done got %0d pulses want 0", n_fd - f0);
      end
   endtask

   task automatic test_async_reset;
      int w0;
      step(1'b1, 8'hC1, 1'b0);
      step(1'b1, 8'hC2, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (we !== 1'b0 || address !== 2'd0 || data_out !== 32'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset got we=%b addr=%0d data=%h busy=%b want 0 0 0 0",
                  we, address, data_out, busy);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      wq.delete();
      fdq.delete();
      m_cnt  = 0;
      m_word = '0;
      m_addr = '0;
      w0 = n_writes;
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hD0 + i), 1'b0);
      idle(3);
      n_tests++;
      if (n_writes - w0 !== 1) begin
         n_fail++;
         $display("FAIL async_reset_write got %0d want 1", n_writes - w0);
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_wrap();
      test_frame_start_mid();
      test_fs_during_write();
      test_async_reset();
      idle(4);
      n_tests++;
      if (wq.size() != 0 || fdq.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got wq=%0d fdq=%0d want 0 0", wq.size(), fdq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
